// File: rtl/gemm_pkg.sv
// Shared types and constants for the GEMM result drain path.
package gemm_pkg;

  localparam int unsigned FP16_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

endpackage

// File: rtl/result_drain_packer_if.sv
// Wide-word host write bus: packed FP16 lanes with lane mask, last flag and valid/ready.
interface result_drain_packer_if #(
  parameter int unsigned LANES = 8
);
  import gemm_pkg::*;

  logic [FP16_W*LANES-1:0] wr_data;
  logic [LANES-1:0]        wr_lane_mask;
  logic                    wr_last;
  logic                    wr_valid;
  logic                    wr_ready;

  modport master (
    output wr_data,
    output wr_lane_mask,
    output wr_last,
    output wr_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_data,
    input  wr_lane_mask,
    input  wr_last,
    input  wr_valid,
    output wr_ready
  );

endinterface

// File: rtl/result_lane_packer.sv
// Collects FP16 results into lane registers and hands full or partial words to the
// write bus, holding the word stable until it is accepted.
module result_lane_packer
  import gemm_pkg::*;
#(
  parameter int unsigned LANES = 8
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_push,
  input  logic [FP16_W-1:0]            i_push_data,
  input  logic                         i_load_req,
  input  logic                         i_load_last,
  output logic [$clog2(LANES+1)-1:0]   o_fill,
  result_drain_packer_if.master        wr_if
);

  localparam int unsigned FILL_W = $clog2(LANES + 1);
  localparam int unsigned WORD_W = FP16_W * LANES;

  logic [WORD_W-1:0] r_lanes;
  logic [FILL_W-1:0] r_fill;
  logic [WORD_W-1:0] r_data;
  logic [LANES-1:0]  r_mask;
  logic              r_last;
  logic              r_valid;

  logic [LANES-1:0]  w_mask;
  logic              w_load;

  // Mask covers the low r_fill lanes.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      w_mask[i] = (FILL_W'(i) < r_fill);
    end
  end

  assign w_load = i_load_req && (!r_valid || wr_if.wr_ready);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lanes <= '0;
      r_fill  <= '0;
      r_data  <= '0;
      r_mask  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      // Lanes are cleared on hand-off so a later partial word has zero upper lanes.
      r_data  <= r_lanes;
      r_mask  <= w_mask;
      r_last  <= i_load_last;
      r_valid <= 1'b1;
      r_lanes <= '0;
      r_fill  <= '0;
    end else begin
      if (wr_if.wr_ready) begin
        r_valid <= 1'b0;
      end
      if (i_push) begin
        for (int i = 0; i < LANES; i++) begin
          if (r_fill == FILL_W'(i)) begin
            r_lanes[i*FP16_W +: FP16_W] <= i_push_data;
          end
        end
        r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

  assign o_fill             = r_fill;
  assign wr_if.wr_data      = r_data;
  assign wr_if.wr_lane_mask = r_mask;
  assign wr_if.wr_last      = r_last;
  assign wr_if.wr_valid     = r_valid;

endmodule

// File: rtl/result_drain_packer.sv
// Drains i_num_results FP16 entries from the result buffer and packs them into wide words.
// Optional perf counters are built when RESULT_DRAIN_PERF_EN is defined.
module result_drain_packer
  import gemm_pkg::*;
#(
  parameter int unsigned LANES = 8,
  parameter int unsigned CNT_W = 15
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [CNT_W-1:0]      i_num_results,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rd_en,
  input  logic [FP16_W-1:0]     i_rd_data,
  input  logic [CNT_W-1:0]      i_count,
  result_drain_packer_if.master wr_if,
  output logic [31:0]           o_stall_cycles,
  output logic [31:0]           o_starve_cycles
);

  localparam int unsigned FILL_W = $clog2(LANES + 1);
  localparam int unsigned OCC_W  = FILL_W + 1;

  drain_state_t      r_state;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_pending;
  logic              r_busy;
  logic              r_done;

  logic [FILL_W-1:0] w_fill;
  logic [OCC_W-1:0]  w_occupancy;
  logic              w_rd_en;
  logic              w_start_acc;
  logic              w_load_req;
  logic              w_load_last;
  logic              w_last_acc;

  // Occupancy counts lanes filled plus the read still in flight.
  assign w_occupancy = OCC_W'(w_fill) + OCC_W'(r_pending);
  assign w_rd_en     = (r_state == DRAIN) && (r_remaining != '0) &&
                       (i_count > CNT_W'(r_pending)) && (w_occupancy < OCC_W'(LANES));
  assign w_start_acc = i_start && (r_state == IDLE);
  // Full words go out during DRAIN; the final word (full or partial) goes out in FLUSH.
  assign w_load_req  = ((r_state == DRAIN) && (r_remaining != '0) && (w_fill == FILL_W'(LANES))) ||
                       ((r_state == FLUSH) && (w_fill != '0));
  assign w_load_last = (r_state == FLUSH);
  assign w_last_acc  = wr_if.wr_valid && wr_if.wr_ready && wr_if.wr_last;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_pending   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_pending <= w_rd_en;
      r_done    <= 1'b0;
      if (w_rd_en) begin
        r_remaining <= r_remaining - CNT_W'(1);
      end
      case (r_state)
        IDLE: begin
          if (w_start_acc) begin
            if (i_num_results == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= DRAIN;
              r_remaining <= i_num_results;
              r_busy      <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if ((r_remaining == '0) && !r_pending) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (w_last_acc) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  result_lane_packer #(
    .LANES (LANES)
  ) u_lane_packer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (r_pending),
    .i_push_data (i_rd_data),
    .i_load_req  (w_load_req),
    .i_load_last (w_load_last),
    .o_fill      (w_fill),
    .wr_if       (wr_if)
  );

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_rd_en = w_rd_en;

`ifdef RESULT_DRAIN_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_starve_cycles;

  // Saturating perf counters, cleared by each accepted command.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_cycles  <= '0;
      r_starve_cycles <= '0;
    end else if (w_start_acc) begin
      r_stall_cycles  <= '0;
      r_starve_cycles <= '0;
    end else begin
      if (r_busy && wr_if.wr_valid && !wr_if.wr_ready && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if ((r_state == DRAIN) && (r_remaining != '0) && (i_count <= CNT_W'(r_pending)) &&
          (r_starve_cycles != '1)) begin
        r_starve_cycles <= r_starve_cycles + 32'd1;
      end
    end
  end

  assign o_stall_cycles  = r_stall_cycles;
  assign o_starve_cycles = r_starve_cycles;
`else
  assign o_stall_cycles  = 32'd0;
  assign o_starve_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_result_drain_packer.sv
// Directed bench for result_drain_packer with a queue-backed result buffer model.
module tb_result_drain_packer;

  localparam int unsigned LANES  = 8;
  localparam int unsigned CNT_W  = 15;
  localparam int unsigned WORD_W = 16 * LANES;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  num;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [15:0]       rd_data;
  logic [CNT_W-1:0]  buf_count;
  logic [31:0]       stall;
  logic [31:0]       starve;

  result_drain_packer_if #(.LANES(LANES)) wr_if ();

  result_drain_packer #(
    .LANES (LANES),
    .CNT_W (CNT_W)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_start         (start),
    .i_num_results   (num),
    .o_busy          (busy),
    .o_done          (done),
    .o_rd_en         (rd_en),
    .i_rd_data       (rd_data),
    .i_count         (buf_count),
    .wr_if           (wr_if),
    .o_stall_cycles  (stall),
    .o_starve_cycles (starve)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0]       buf_q[$];
  logic [WORD_W-1:0] w_data_q[$];
  logic [LANES-1:0]  w_mask_q[$];
  logic              w_last_q[$];

  int cyc_n = 0;
  int rd_pulses, bad_reads, underflows, done_cnt, done_cyc, last_acc_cyc;
  int first_rd_cyc, valid_cnt, hold_err, start_cyc;
  int feed_total = 0;
  int feed_cnt = 0;
  logic [15:0] feed_base = 16'h0;
  logic pend_tb = 1'b0;
  logic prev_stall = 1'b0;
  logic [WORD_W-1:0] prev_data;
  logic [LANES-1:0]  prev_mask;
  logic              prev_last;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs at negedge, then update the buffer model after posedge.
  task automatic cyc();
    logic p_next;
    @(negedge clk);
    if (rd_en) begin
      rd_pulses++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc_n;
      if (buf_count <= CNT_W'(pend_tb)) bad_reads++;
    end
    if (wr_if.wr_valid) valid_cnt++;
    if (prev_stall && (!wr_if.wr_valid || wr_if.wr_data !== prev_data ||
                       wr_if.wr_lane_mask !== prev_mask || wr_if.wr_last !== prev_last))
      hold_err++;
    prev_stall = wr_if.wr_valid && !wr_if.wr_ready;
    prev_data  = wr_if.wr_data;
    prev_mask  = wr_if.wr_lane_mask;
    prev_last  = wr_if.wr_last;
    if (wr_if.wr_valid && wr_if.wr_ready) begin
      w_data_q.push_back(wr_if.wr_data);
      w_mask_q.push_back(wr_if.wr_lane_mask);
      w_last_q.push_back(wr_if.wr_last);
      if (wr_if.wr_last) last_acc_cyc = cyc_n;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
    p_next = rd_en;
    @(posedge clk);
    #1;
    cyc_n++;
    if (p_next) begin
      if (buf_q.size() == 0) begin
        underflows++;
        rd_data = 16'hDEAD;
      end else begin
        rd_data = buf_q.pop_front();
      end
    end
    pend_tb = p_next;
    if (feed_cnt < feed_total && (cyc_n % 5) == 0) begin
      buf_q.push_back(feed_base + 16'(feed_cnt));
      feed_cnt++;
    end
    buf_count = CNT_W'(buf_q.size());
  endtask

  task automatic clr_log();
    w_data_q.delete();
    w_mask_q.delete();
    w_last_q.delete();
    rd_pulses = 0; bad_reads = 0; underflows = 0; done_cnt = 0;
    done_cyc = -1; last_acc_cyc = -100; first_rd_cyc = -1; valid_cnt = 0; hold_err = 0;
    prev_stall = 1'b0;
  endtask

  task automatic preload(input int n, input logic [15:0] base);
    buf_q.delete();
    for (int k = 0; k < n; k++) buf_q.push_back(base + 16'(k));
    buf_count = CNT_W'(buf_q.size());
  endtask

  task automatic start_cmd(input int n);
    num = CNT_W'(n);
    start = 1'b1;
    start_cyc = cyc_n;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      cyc();
      k++;
    end
    chk_i({tag, ".done_seen"}, done_cnt, 1);
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [15:0] base,
                          input int nvalid, input logic last);
    logic [WORD_W-1:0] ed;
    logic [LANES-1:0]  em;
    ed = '0;
    em = '0;
    for (int k = 0; k < nvalid; k++) begin
      ed = ed | (WORD_W'(base + 16'(k)) << (16 * k));
      em = em | (LANES'(1) << k);
    end
    if (idx < w_data_q.size()) begin
      chk({tag, ".data"}, 128'(w_data_q[idx]), 128'(ed));
      chk({tag, ".mask"}, 128'(w_mask_q[idx]), 128'(em));
      chk({tag, ".last"}, 128'(w_last_q[idx]), 128'(last));
    end else begin
      chk_i({tag, ".present"}, w_data_q.size(), idx + 1);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".rd_en"}, 128'(rd_en), 128'(0));
    chk({tag, ".busy"}, 128'(busy), 128'(0));
    chk({tag, ".done"}, 128'(done), 128'(0));
    chk({tag, ".valid"}, 128'(wr_if.wr_valid), 128'(0));
    chk({tag, ".data"}, 128'(wr_if.wr_data), 128'(0));
    chk({tag, ".mask"}, 128'(wr_if.wr_lane_mask), 128'(0));
    chk({tag, ".last"}, 128'(wr_if.wr_last), 128'(0));
    chk({tag, ".stall"}, 128'(stall), 128'(0));
    chk({tag, ".starve"}, 128'(starve), 128'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num = '0; rd_data = '0; buf_count = '0;
    wr_if.wr_ready = 1'b1;
    clr_log();
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk_idle_outputs("reset");

    // 1: two full words, ready always high
    preload(16, 16'h3C00); clr_log();
    start_cmd(16);
    wait_done("t1", 200);
    chk_i("t1.nwords", w_data_q.size(), 2);
    chk_word("t1.w0", 0, 16'h3C00, 8, 1'b0);
    chk_word("t1.w1", 1, 16'h3C08, 8, 1'b1);
    chk_i("t1.done_lat", done_cyc, last_acc_cyc + 1);
    chk_i("t1.first_rd", first_rd_cyc, start_cyc + 1);
    chk_i("t1.rd_pulses", rd_pulses, 16);
    chk_i("t1.bad_reads", bad_reads + underflows, 0);
    chk("t1.busy_after", 128'(busy), 128'(0));

    // 2: partial final word
    preload(11, 16'h4000); clr_log();
    start_cmd(11);
    wait_done("t2", 200);
    chk_i("t2.nwords", w_data_q.size(), 2);
    chk_word("t2.w0", 0, 16'h4000, 8, 1'b0);
    chk_word("t2.w1", 1, 16'h4008, 3, 1'b1);
    chk_i("t2.rd_pulses", rd_pulses, 11);
    chk_i("t2.done_lat", done_cyc, last_acc_cyc + 1);

    // 3: downstream stall of 20 cycles with the first word held
    preload(24, 16'h5000); clr_log();
    wr_if.wr_ready = 1'b0;
    start_cmd(24);
    for (int k = 0; k < 100 && !wr_if.wr_valid; k++) cyc();
    chk("t3.valid_up", 128'(wr_if.wr_valid), 128'(1));
    for (int k = 0; k < 20; k++) cyc();
    chk_i("t3.rd_during_stall", rd_pulses, 16);
    wr_if.wr_ready = 1'b1;
    wait_done("t3", 200);
    chk_i("t3.nwords", w_data_q.size(), 3);
    chk_word("t3.w0", 0, 16'h5000, 8, 1'b0);
    chk_word("t3.w1", 1, 16'h5008, 8, 1'b0);
    chk_word("t3.w2", 2, 16'h5010, 8, 1'b1);
    chk_i("t3.hold", hold_err, 0);
    chk_i("t3.rd_pulses", rd_pulses, 24);
`ifdef RESULT_DRAIN_PERF_EN
    chk("t3.stall", 128'(stall), 128'(20));
`else
    chk("t3.stall", 128'(stall), 128'(0));
`endif

    // 4: slow producer, one entry every 5 cycles
    buf_q.delete(); buf_count = '0; clr_log();
    feed_base = 16'h6000; feed_cnt = 0; feed_total = 8;
    start_cmd(8);
    wait_done("t4", 300);
    chk_i("t4.bad_reads", bad_reads + underflows, 0);
    chk_i("t4.nwords", w_data_q.size(), 1);
    chk_word("t4.w0", 0, 16'h6000, 8, 1'b1);
    chk_i("t4.rd_pulses", rd_pulses, 8);
`ifdef RESULT_DRAIN_PERF_EN
    chk("t4.starved", 128'(starve != 32'd0), 128'(1));
`else
    chk("t4.starve", 128'(starve), 128'(0));
`endif
    feed_total = 0;

    // 5a: zero-length command
    preload(4, 16'h7000); clr_log();
    start_cmd(0);
    cyc();
    cyc(); cyc(); cyc();
    chk_i("t5.done_cyc", done_cyc, start_cyc + 1);
    chk_i("t5.done_cnt", done_cnt, 1);
    chk_i("t5.rd_pulses", rd_pulses, 0);
    chk_i("t5.valid_cnt", valid_cnt, 0);

    // 5b: start while busy is ignored
    preload(11, 16'h7100); clr_log();
    wr_if.wr_ready = 1'b0;
    start_cmd(8);
    cyc(); cyc(); cyc();
    start_cmd(3);
    wr_if.wr_ready = 1'b1;
    wait_done("t5b", 200);
    for (int k = 0; k < 5; k++) cyc();
    chk_i("t5b.done_cnt", done_cnt, 1);
    chk_i("t5b.nwords", w_data_q.size(), 1);
    chk_word("t5b.w0", 0, 16'h7100, 8, 1'b1);
    chk_i("t5b.rd_pulses", rd_pulses, 8);
    chk_i("t5b.left", buf_q.size(), 3);

    // 6: reset mid-DRAIN, then a clean command
    preload(16, 16'h7200); clr_log();
    start_cmd(16);
    for (int k = 0; k < 12; k++) cyc();
    chk("t6.word_out", 128'(w_data_q.size() != 0), 128'(1));
    rst = 1'b1;
    #1;
    chk_idle_outputs("t6.rst");
    cyc(); cyc();
    rst = 1'b0;
    preload(8, 16'h7300); clr_log();
    start_cmd(8);
    wait_done("t6", 200);
    chk_i("t6.nwords", w_data_q.size(), 1);
    chk_word("t6.w0", 0, 16'h7300, 8, 1'b1);
    chk_i("t6.rd_pulses", rd_pulses, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
